pattern_serializer: RTL

- Transmit side of the 4-bit pattern link whose receiver decodes the word on the A,B,C,D inputs (the detector raises Y only for A=0,B=1,C=1,D=0).
- Accepts one parallel word and sends it as a framed serial stream on a single line, so a remote deserializer can rebuild A..D and feed the pattern detector.
- Framing: start bit, data MSB-first (A first), stop bit, with a fixed bit period set by a clock divider.

---
 rtl/pattern_serializer.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/pattern_serializer.sv
// pattern_serializer: sends one parallel pattern word as a framed serial
// stream (start bit, data MSB-first, stop bit) with DIV clocks per bit.
//
// Optional feature: define PATTERN_SERIALIZER_PARITY_EN to insert an
// even-parity bit between the data bits and the stop bit.
//
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous reset, active-low
//   start  - send request, accepted only while ready
//   din    - parallel word, captured on the accepted start edge
//   ready  - idle and able to accept start (registered)
//   busy   - frame in progress, inverse of ready (registered)
//   sout   - serial line, idles high (registered)
//   done   - one-cycle pulse after the last stop-bit cycle (registered)
module pattern_serializer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DIV   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  output logic             ready,
  output logic             busy,
  output logic             sout,
  output logic             done
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    STRT = 3'd1,
    DATA = 3'd2,
`ifdef PATTERN_SERIALIZER_PARITY_EN
    PRTY = 3'd4,
`endif
    STOP = 3'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             sout_d, done_d, ready_d;
  logic             bit_end;

  assign bit_end = (cnt_q == DIV_LAST);

`ifdef PATTERN_SERIALIZER_PARITY_EN
  // Parity is taken from the word at capture, since the shifter discards bits.
  logic par_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else if (state_q == IDLE && start) begin
      par_q <= ^din;
    end
  end
`endif

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      sout    <= 1'b1;
      done    <= 1'b0;
      ready   <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      sout    <= sout_d;
      done    <= done_d;
      ready   <= ready_d;
      busy    <= ~ready_d;
    end
  end

  // Next state plus divider, bit index and shifter updates.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d = STRT;
          sh_d    = din;
        end
      end
      STRT: begin
        if (bit_end) begin
          cnt_d   = '0;
          idx_d   = BIT_LAST;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          sh_d  = sh_q << 1;
          if (idx_q == '0) begin
`ifdef PATTERN_SERIALIZER_PARITY_EN
            state_d = PRTY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q - 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef PATTERN_SERIALIZER_PARITY_EN
      PRTY: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output values for the state being entered, so sout leads with no lag.
  always_comb begin
    sout_d  = 1'b1;
    ready_d = 1'b0;
    done_d  = (state_q == STOP) && bit_end;
    case (state_d)
      IDLE: ready_d = 1'b1;
      STRT: sout_d  = 1'b0;
      DATA: sout_d  = sh_d[WIDTH-1];
`ifdef PATTERN_SERIALIZER_PARITY_EN
      PRTY: sout_d  = par_q;
`endif
      STOP: sout_d  = 1'b1;
      default: sout_d = 1'b1;
    endcase
  end

endmodule
